receptor_serial_contador: RTL
=============================

// Module: receptor_serial_contador
// PURPOSE
// - Serial receiver for 7-bit words shifted out LSB-first (bit0 first) by the shift/counter chain.
// - Deserializes one framed word per transaction: start, WIDTH data bits, optional parity, stop.
// - Presents the word in parallel with a one-cycle valid pulse.
// - Sits downstream of the counter's serial output, on the same clk domain.
// PARAMETERS
// - WIDTH  default 7  number of data bits per frame (2..16)
// PORTS
// - clk            in   1      system clock, rising edge
// - rst            in   1      asynchronous reset, active-high
// - en             in   1      bit strobe; sdi is sampled only on clk edges where en=1
// - sdi            in   1      serial data in; idle level 0
// - dado           out  WIDTH  last correctly received word; holds until next good frame
// - valido         out  1      one-cycle pulse: dado updated this cycle
// - erro_quadro    out  1      one-cycle pulse: stop bit was 1 (framing error)
// - erro_paridade  out  1      one-cycle pulse: parity mismatch (tied 0 without macro)
// - ocupado        out  1      1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, cnt=0, shreg=0, dado=0, valido=0, erro_quadro=0,
//   erro_paridade=0, ocupado=0. Reset mid-frame aborts the frame; no pulse is issued.
// - All state changes occur only on clk edges with en=1, except pulse clearing.
// - Pulse outputs are registered and self-clear on the next clk edge regardless of en.
// - FSM states: IDLE, DADOS, PARIDADE (macro only), PARADA.
//   - IDLE:     en&sdi=1 (start bit) -> DADOS, cnt=0. en&sdi=0 -> stay.
//   - DADOS:    en: shreg[cnt]<=sdi, cnt<=cnt+1. When cnt==WIDTH-1 -> PARIDADE (macro) or
//               PARADA (no macro). Bit 0 of the word is received first.
//   - PARIDADE: en: store sdi as the received parity bit -> PARADA.
//   - PARADA:   en&sdi=0: good stop. If no parity error -> dado<=shreg, valido=1.
//               Parity error -> erro_paridade=1, dado unchanged.
//               en&sdi=1: erro_quadro=1, dado unchanged (takes priority over parity error).
//               Both cases -> IDLE.
// - Latency: valido rises on the clk edge that samples the stop bit. dado is valid in the
//   same cycle as valido.
// - cnt: $clog2(WIDTH+1) bits. It wraps only through state exit and never exceeds WIDTH-1.
// - Back-to-back frames: the strobe after the stop bit may be the next start bit.
//   The block does not require an idle gap.
// - en held low: the FSM freezes in its current state indefinitely. No timeout.
// - sdi=X while en=0 is ignored.
// CONFIGURATION
// - PARITY_CHECK_EN defined: PARIDADE state is present.
//   - The frame carries 1 even-parity bit after the data bits.
//   - The XOR of the data bits and the parity bit must be 0. Otherwise erro_paridade pulses.
//   - Frame length is WIDTH+3 strobes.
// - Not defined: no PARIDADE state. erro_paridade is constant 0. Frame length is WIDTH+2 strobes.
// TESTING
// - Reset: assert rst mid-frame (after 3 data bits).
//   -> All outputs are 0 immediately. The next full frame 7'h55 is received cleanly.
// - Frame: en=1 every cycle, serial 1,(1010101),[p=0],0.
//   -> dado=7'h55 and valido=1 for exactly one cycle. ocupado drops with it.
// - Framing error: frame 7'h7F with stop bit=1.
//   -> erro_quadro=1 for one cycle, valido=0, dado keeps its previous value.
// - Sparse strobe: en=1 every 4th cycle, frame 7'h01.
//   -> dado=7'h01. sdi glitches between strobes have no effect.
// - Back-to-back: frames 7'h12 then 7'h6D with no gap strobes.
//   -> two valido pulses, dado=7'h12 then 7'h6D.
// - PARITY_CHECK_EN: frame 7'h03 with parity bit=1.
//   -> erro_paridade=1, valido=0. With parity bit=0 -> valido=1, dado=7'h03.

Source files
------------

// File: rtl/receptor_serial_contador.sv
// receptor_serial_contador
//
// Serial receiver for framed words shifted out LSB-first by the shift/counter
// chain. It runs on the same clock domain as that chain. A frame is a start
// bit (1), WIDTH data bits with bit 0 first, an optional even-parity bit, and
// a stop bit (0). The received word is presented in parallel together with a
// one-cycle valid pulse.
//
// Optional feature: define PARITY_CHECK_EN to add the PARIDADE state. A frame
// then carries one even-parity bit after the data bits. Without the macro
// erro_paridade is tied to 0.
//
// Ports
//   clk            in   1      system clock, rising edge
//   rst            in   1      asynchronous reset, active-high
//   en             in   1      bit strobe; sdi is sampled only on edges with en=1
//   sdi            in   1      serial data in, idle level 0
//   dado           out  WIDTH  last correctly received word
//   valido         out  1      one-cycle pulse: dado updated this cycle
//   erro_quadro    out  1      one-cycle pulse: stop bit was 1
//   erro_paridade  out  1      one-cycle pulse: parity mismatch
//   ocupado        out  1      frame in progress
module receptor_serial_contador #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sdi,
    output logic [WIDTH-1:0] dado,
    output logic             valido,
    output logic             erro_quadro,
    output logic             erro_paridade,
    output logic             ocupado
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DADOS    = 2'd1,
        PARIDADE = 2'd2,
        PARADA   = 2'd3
    } estado_t;

    estado_t          estado;
    estado_t          proximo;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             valido_d;
    logic             quadro_d;

`ifdef PARITY_CHECK_EN
    logic bit_par;
    logic erro_par_calc;
    logic paridade_d;
    logic erro_paridade_r;

    // Even parity: data bits XOR parity bit must be 0 for a good frame.
    assign erro_par_calc = ^{shreg, bit_par};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_par         <= 1'b0;
            erro_paridade_r <= 1'b0;
        end else begin
            erro_paridade_r <= paridade_d;
            if (en && estado == PARIDADE)
                bit_par <= sdi;
        end
    end

    assign erro_paridade = erro_paridade_r;
`else
    assign erro_paridade = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            estado <= IDLE;
        else
            estado <= proximo;
    end

    // Next-state logic; every transition is qualified by the bit strobe
    always_comb begin
        proximo = estado;
        case (estado)
            IDLE: begin
                if (en && sdi)
                    proximo = DADOS;
            end
            DADOS: begin
                if (en && cnt == ULTIMO)
`ifdef PARITY_CHECK_EN
                    proximo = PARIDADE;
`else
                    proximo = PARADA;
`endif
            end
            PARIDADE: begin
`ifdef PARITY_CHECK_EN
                if (en)
                    proximo = PARADA;
`else
                proximo = IDLE;
`endif
            end
            PARADA: begin
                if (en)
                    proximo = IDLE;
            end
            default: proximo = IDLE;
        endcase
    end

    // Output logic: decide which pulse the stop-bit strobe raises.
    // A framing error wins over a parity error.
    always_comb begin
        valido_d   = 1'b0;
        quadro_d   = 1'b0;
`ifdef PARITY_CHECK_EN
        paridade_d = 1'b0;
`endif
        if (en && estado == PARADA) begin
            if (sdi)
                quadro_d = 1'b1;
`ifdef PARITY_CHECK_EN
            else if (erro_par_calc)
                paridade_d = 1'b1;
`endif
            else
                valido_d = 1'b1;
        end
    end

    // Datapath and pulse registers; pulses self-clear on the next edge
    // regardless of en because they are reloaded every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            shreg       <= '0;
            dado        <= '0;
            valido      <= 1'b0;
            erro_quadro <= 1'b0;
        end else begin
            valido      <= valido_d;
            erro_quadro <= quadro_d;
            if (valido_d)
                dado <= shreg;
            if (en) begin
                case (estado)
                    IDLE: cnt <= '0;
                    DADOS: begin
                        shreg[cnt] <= sdi;
                        // Wrap on exit so cnt never goes past WIDTH-1.
                        cnt <= (cnt == ULTIMO) ? '0 : cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ocupado = (estado != IDLE);

endmodule
